// File: rtl/mipi_packet_ctrl.sv
// MIPI CSI-2 two-lane packet parser: header decode, payload forwarding,
// short-packet strobes, error aborts and lane resync sequencing.
module mipi_packet_ctrl #(
    parameter int unsigned RESYNC_WAIT = 16,
    parameter int unsigned ECC_CHECK   = 0
) (
    input  logic        I_CLK,
    input  logic        I_Rst_n,
    input  logic [15:0] I_Lane_Data,
    input  logic        I_Lane_Vaild,
    input  logic        I_ReSearch_Offset_Lane,
    output logic        O_Unpacket_done,
    output logic        O_Lane_ReSync,
    output logic [5:0]  O_Data_Type,
    output logic [1:0]  O_Virtual_Ch,
    output logic [15:0] O_Word_Count,
    output logic [15:0] O_Payload_Data,
    output logic        O_Payload_Vaild,
    output logic        O_Frame_Start,
    output logic        O_Frame_End,
    output logic        O_Line_Start,
    output logic        O_Line_End,
    output logic        O_Pkt_Error
);

    localparam int unsigned CNT_W = 15;
    localparam int unsigned RS_W  = 8;
    localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESYNC_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CRC,
        ST_RESYNC
    } state_t;

    state_t            state;
    logic [7:0]        di_q;
    logic [7:0]        wc_lo_q;
    logic [CNT_W-1:0]  word_cnt;
    logic [RS_W-1:0]   rs_cnt;
    logic              research_q;
    logic              armed;

    // Header fields as seen while the second header word is on the bus.
    logic [15:0] hdr_wc;
    logic [7:0]  hdr_ecc;
    logic        hdr_short;
    logic        ecc_bad;
    logic        research_rise;

    assign hdr_wc        = {I_Lane_Data[7:0], wc_lo_q};
    assign hdr_ecc       = I_Lane_Data[15:8];
    assign hdr_short     = (di_q[5:0] <= 6'h0F);
    assign ecc_bad       = (ECC_CHECK != 0) && (hdr_ecc == 8'h00);
    assign research_rise = I_ReSearch_Offset_Lane && !research_q;

    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state           <= ST_IDLE;
            di_q            <= 8'h00;
            wc_lo_q         <= 8'h00;
            word_cnt        <= '0;
            rs_cnt          <= '0;
            research_q      <= 1'b0;
            armed           <= 1'b1;
            O_Unpacket_done <= 1'b0;
            O_Lane_ReSync   <= 1'b0;
            O_Data_Type     <= 6'h00;
            O_Virtual_Ch    <= 2'b00;
            O_Word_Count    <= 16'h0000;
            O_Payload_Data  <= 16'h0000;
            O_Payload_Vaild <= 1'b0;
            O_Frame_Start   <= 1'b0;
            O_Frame_End     <= 1'b0;
            O_Line_Start    <= 1'b0;
            O_Line_End      <= 1'b0;
            O_Pkt_Error     <= 1'b0;
        end else begin
            O_Unpacket_done <= 1'b0;
            O_Lane_ReSync   <= 1'b0;
            O_Payload_Vaild <= 1'b0;
            O_Frame_Start   <= 1'b0;
            O_Frame_End     <= 1'b0;
            O_Line_Start    <= 1'b0;
            O_Line_End      <= 1'b0;
            O_Pkt_Error     <= 1'b0;
            research_q      <= I_ReSearch_Offset_Lane;

            // A low valid cycle re-arms header acceptance after a packet close.
            if (!I_Lane_Vaild) begin
                armed <= 1'b1;
            end

            if (research_rise) begin
                state         <= ST_RESYNC;
                O_Lane_ReSync <= 1'b1;
                rs_cnt        <= '0;
                word_cnt      <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (I_Lane_Vaild && armed) begin
                            di_q    <= I_Lane_Data[7:0];
                            wc_lo_q <= I_Lane_Data[15:8];
                            state   <= ST_HDR1;
                        end
                    end

                    ST_HDR1: begin
                        if (!I_Lane_Vaild || ecc_bad) begin
                            O_Pkt_Error     <= 1'b1;
                            O_Unpacket_done <= 1'b1;
                            word_cnt        <= '0;
                            state           <= ST_IDLE;
                            if (I_Lane_Vaild) begin
                                armed <= 1'b0;
                            end
                        end else if (hdr_short) begin
                            O_Data_Type     <= di_q[5:0];
                            O_Virtual_Ch    <= di_q[7:6];
                            O_Unpacket_done <= 1'b1;
                            armed           <= 1'b0;
                            state           <= ST_IDLE;
                            case (di_q[5:0])
                                6'h00:   O_Frame_Start <= 1'b1;
                                6'h01:   O_Frame_End   <= 1'b1;
                                6'h02:   O_Line_Start  <= 1'b1;
                                6'h03:   O_Line_End    <= 1'b1;
                                default: ;
                            endcase
                        end else if (hdr_wc == 16'h0000) begin
                            O_Data_Type  <= di_q[5:0];
                            O_Virtual_Ch <= di_q[7:6];
                            O_Word_Count <= hdr_wc;
                            state        <= ST_CRC;
                        end else if (hdr_wc[0]) begin
                            // Odd byte counts cannot be carried on two lanes.
                            O_Pkt_Error     <= 1'b1;
                            O_Unpacket_done <= 1'b1;
                            armed           <= 1'b0;
                            state           <= ST_IDLE;
                        end else begin
                            O_Data_Type  <= di_q[5:0];
                            O_Virtual_Ch <= di_q[7:6];
                            O_Word_Count <= hdr_wc;
                            word_cnt     <= hdr_wc[15:1];
                            state        <= ST_PAYLOAD;
                        end
                    end

                    ST_PAYLOAD: begin
                        if (!I_Lane_Vaild) begin
                            O_Pkt_Error     <= 1'b1;
                            O_Unpacket_done <= 1'b1;
                            word_cnt        <= '0;
                            state           <= ST_IDLE;
                        end else begin
                            O_Payload_Data  <= I_Lane_Data;
                            O_Payload_Vaild <= 1'b1;
                            word_cnt        <= word_cnt - CNT_W'(1);
                            if (word_cnt == CNT_W'(1)) begin
                                state <= ST_CRC;
                            end
                        end
                    end

                    ST_CRC: begin
                        O_Unpacket_done <= 1'b1;
                        state           <= ST_IDLE;
                        if (!I_Lane_Vaild) begin
                            O_Pkt_Error <= 1'b1;
                            word_cnt    <= '0;
                        end else begin
                            armed <= 1'b0;
                        end
                    end

                    ST_RESYNC: begin
                        if (rs_cnt == RS_LAST) begin
                            rs_cnt <= '0;
                            armed  <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            rs_cnt <= rs_cnt + RS_W'(1);
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
